manual_drive_fsm: RTL



---
 rtl/car_pkg.sv | 27 ++
 rtl/speed_ramp.sv | 102 ++++++++++
 rtl/manual_drive_fsm.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/car_pkg.sv
// ---------------------------------------------------------------------------
// car_pkg
// Shared definitions for the car simulator blocks. The engine state encoding
// is shared with the display and auto-drive blocks, so keep these values fixed.
//   car_state_t : engine state (OFF / NOT_STARTING / STARTING / MOVING)
//   ramp_mode_t : what the speed ramp does with the next tick
// ---------------------------------------------------------------------------
package car_pkg;

    localparam int CAR_STATE_W = 2;

    typedef enum logic [CAR_STATE_W-1:0] {
        OFF          = 2'b00,
        NOT_STARTING = 2'b01,
        STARTING     = 2'b11,
        MOVING       = 2'b10
    } car_state_t;

    // Clear forces speed to zero immediately; the other modes act on ticks.
    typedef enum logic [1:0] {
        RAMP_CLEAR = 2'b00,
        RAMP_ACCEL = 2'b01,
        RAMP_COAST = 2'b10,
        RAMP_BRAKE = 2'b11
    } ramp_mode_t;

endpackage : car_pkg

// File: rtl/speed_ramp.sv
// ---------------------------------------------------------------------------
// speed_ramp
// Tick-divided, saturating up/down speed register.
//   clk, rst  : clock and asynchronous active-high reset
//   enable    : low holds every register; ticks seen while low are lost
//   tick      : one-cycle time-base pulse
//   mode      : ramp_mode_t (clear / accel / coast / brake)
//   speed     : registered speed level, 0..SPEED_MAX
// ---------------------------------------------------------------------------
module speed_ramp
    import car_pkg::*;
#(
    parameter int SPEED_W   = 4,
    parameter int SPEED_MAX = 15,
    parameter int ACCEL_DIV = 8,
    parameter int DECEL_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               tick,
    input  logic [1:0]         mode,
    output logic [SPEED_W-1:0] speed
);

    localparam int DIV_MAX = (ACCEL_DIV > DECEL_DIV) ? ACCEL_DIV : DECEL_DIV;
    localparam int CNT_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    localparam logic [CNT_W-1:0]   ACCEL_LAST = CNT_W'(ACCEL_DIV - 1);
    localparam logic [CNT_W-1:0]   DECEL_LAST = CNT_W'(DECEL_DIV - 1);
    localparam logic [SPEED_W-1:0] SPEED_TOP  = SPEED_W'(SPEED_MAX);

    ramp_mode_t       cur_mode;
    ramp_mode_t       prev_mode;
    logic [CNT_W-1:0] sub_cnt;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;
    logic [SPEED_W-1:0] speed_next;

    // Next-state for the sub-counter and speed. A mode change restarts the
    // divider from zero, and the tick arriving on that same cycle already
    // counts as the first tick of the new mode.
    always_comb begin
        cur_mode   = ramp_mode_t'(mode);
        cnt_base   = (cur_mode != prev_mode) ? '0 : sub_cnt;
        cnt_next   = cnt_base;
        speed_next = speed;
        case (cur_mode)
            RAMP_CLEAR: begin
                cnt_next   = '0;
                speed_next = '0;
            end
            RAMP_ACCEL: begin
                if (tick) begin
                    if (cnt_base == ACCEL_LAST) begin
                        cnt_next = '0;
                        if (speed < SPEED_TOP)
                            speed_next = speed + 1'b1;
                    end else begin
                        cnt_next = cnt_base + 1'b1;
                    end
                end
            end
            RAMP_COAST: begin
                if (tick) begin
                    if (cnt_base == DECEL_LAST) begin
                        cnt_next = '0;
                        if (speed != '0)
                            speed_next = speed - 1'b1;
                    end else begin
                        cnt_next = cnt_base + 1'b1;
                    end
                end
            end
            RAMP_BRAKE: begin
                if (tick) begin
                    cnt_next = '0;
                    if (speed != '0)
                        speed_next = speed - 1'b1;
                end
            end
            default: begin
                cnt_next   = '0;
                speed_next = '0;
            end
        endcase
    end

    // Ramp registers; everything freezes while the block is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_cnt   <= '0;
            speed     <= '0;
            prev_mode <= RAMP_CLEAR;
        end else if (enable) begin
            sub_cnt   <= cnt_next;
            speed     <= speed_next;
            prev_mode <= cur_mode;
        end
    end

endmodule : speed_ramp

// File: rtl/manual_drive_fsm.sv
// ---------------------------------------------------------------------------
// manual_drive_fsm
// Manual-transmission drive controller: engine state machine, latched travel
// direction, tick-driven speed ramp and saturating mileage accumulator.
//   clk, rst                 : clock, asynchronous active-high reset
//   enable                   : manual mode; low freezes state, blanks outputs
//   tick                     : simulation time-base pulse
//   power_on / power_off     : engine start / stop requests
//   reverse                  : reverse gear selected
//   brake, clutch, throttle  : pedals
//   left, right              : turn inputs
//   state                    : car_state_t encoding of the engine state
//   speed                    : current speed level
//   dir_back                 : latched direction (1 = reverse)
//   move_forward/_backward   : vehicle moving in latched direction
//   turn_left / turn_right   : registered turn indication
//   stall                    : one-cycle pulse on forced engine cut-off
//   mileage                  : saturating distance accumulator
// ---------------------------------------------------------------------------
module manual_drive_fsm
    import car_pkg::*;
#(
    parameter int SPEED_W   = 4,
    parameter int SPEED_MAX = 15,
    parameter int ACCEL_DIV = 8,
    parameter int DECEL_DIV = 4,
    parameter int MILE_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               tick,
    input  logic               power_on,
    input  logic               power_off,
    input  logic               reverse,
    input  logic               brake,
    input  logic               clutch,
    input  logic               throttle,
    input  logic               left,
    input  logic               right,
    output logic [1:0]         state,
    output logic [SPEED_W-1:0] speed,
    output logic               dir_back,
    output logic               move_forward,
    output logic               move_backward,
    output logic               turn_left,
    output logic               turn_right,
    output logic               stall,
    output logic [MILE_W-1:0]  mileage
);

    car_state_t  state_q;
    ramp_mode_t  ramp_mode;
    logic        dir_conflict;
    logic        stall_q;
    logic        turn_left_q;
    logic        turn_right_q;
    logic [MILE_W:0] mile_sum;

    // A gear change against the latched direction without the clutch is the
    // one MOVING condition that kills the engine.
    assign dir_conflict = (reverse != dir_back) && !clutch;

    // Ramp behaviour is only meaningful in MOVING; any exit path (power off
    // or stall) clears speed on the same edge the state changes.
    always_comb begin
        ramp_mode = RAMP_CLEAR;
        if (state_q == MOVING && !power_off && !dir_conflict) begin
            if (brake)
                ramp_mode = RAMP_BRAKE;
            else if (throttle && !clutch)
                ramp_mode = RAMP_ACCEL;
            else
                ramp_mode = RAMP_COAST;
        end
    end

    speed_ramp #(
        .SPEED_W   (SPEED_W),
        .SPEED_MAX (SPEED_MAX),
        .ACCEL_DIV (ACCEL_DIV),
        .DECEL_DIV (DECEL_DIV)
    ) u_speed_ramp (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick),
        .mode   (ramp_mode),
        .speed  (speed)
    );

    // One extra bit catches overflow so the accumulator can saturate.
    assign mile_sum = {1'b0, mileage} + {{(MILE_W + 1 - SPEED_W){1'b0}}, speed};

    // Engine state machine plus the registers that travel with it: direction
    // latch, stall pulse, turn indication and mileage. While disabled the
    // state holds and the pulse/turn registers drop to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= OFF;
            dir_back     <= 1'b0;
            stall_q      <= 1'b0;
            turn_left_q  <= 1'b0;
            turn_right_q <= 1'b0;
            mileage      <= '0;
        end else if (!enable) begin
            stall_q      <= 1'b0;
            turn_left_q  <= 1'b0;
            turn_right_q <= 1'b0;
        end else begin
            stall_q      <= 1'b0;
            turn_left_q  <= (state_q == STARTING || state_q == MOVING) && left && !right;
            turn_right_q <= (state_q == STARTING || state_q == MOVING) && right && !left;

            if (tick && state_q == MOVING)
                mileage <= mile_sum[MILE_W] ? '1 : mile_sum[MILE_W-1:0];

            case (state_q)
                OFF: begin
                    if (power_on)
                        state_q <= NOT_STARTING;
                end
                NOT_STARTING: begin
                    if (power_off) begin
                        state_q <= OFF;
                    end else if (throttle && clutch && !brake) begin
                        state_q <= STARTING;
                    end else if (!clutch && ((throttle && !brake) || (reverse && !throttle))) begin
                        state_q <= OFF;
                        stall_q <= 1'b1;
                    end
                end
                STARTING: begin
                    if (power_off) begin
                        state_q <= OFF;
                    end else if (brake) begin
                        state_q <= NOT_STARTING;
                    end else if (throttle && !clutch) begin
                        state_q  <= MOVING;
                        dir_back <= reverse;
                    end else if (reverse && !clutch && !throttle) begin
                        state_q <= OFF;
                        stall_q <= 1'b1;
                    end
                end
                MOVING: begin
                    if (power_off) begin
                        state_q <= OFF;
                    end else if (dir_conflict) begin
                        state_q <= OFF;
                        stall_q <= 1'b1;
                    end else if (speed == '0 && !throttle) begin
                        state_q <= brake ? NOT_STARTING : STARTING;
                    end
                end
                default: state_q <= OFF;
            endcase
        end
    end

    // Motion flags decode the registered state directly; all display-facing
    // flags are blanked as soon as manual mode is deselected.
    assign state         = state_q;
    assign move_forward  = enable && (state_q == MOVING) && (speed != '0) && !dir_back;
    assign move_backward = enable && (state_q == MOVING) && (speed != '0) && dir_back;
    assign turn_left     = enable && turn_left_q;
    assign turn_right    = enable && turn_right_q;
    assign stall         = enable && stall_q;

endmodule : manual_drive_fsm
